iq_rotator: RTL and testbench



---
 rtl/iq_rotator.sv | 141 ++++++++++++++
 tb/tb_iq_rotator.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/iq_rotator.sv
// iq_rotator: multi-lane I/Q complex rotator (e^(+j*theta)) with a fixed 4-clock pipeline.
// Optional macro MULT_CONJ_EN switches the rotation to e^(-j*theta) for demodulation.
module iq_rotator #(
  parameter int unsigned LANES    = 5,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned PHASE_W  = 14,
  parameter int unsigned LUT_BITS = 10
) (
  input  logic                       clk100,
  input  logic                       reset,
  input  logic [LANES*PHASE_W-1:0]   phase_vals,
  input  logic [LANES*DATA_W-1:0]    data_i_in,
  input  logic [LANES*DATA_W-1:0]    data_q_in,
  output logic [LANES*DATA_W-1:0]    data_i_rot,
  output logic [LANES*DATA_W-1:0]    data_q_rot
);

  localparam int unsigned COEF_W = 16;
  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam int unsigned SUM_W  = PROD_W + 1;
  localparam int unsigned A_W    = LUT_BITS - 2;
  localparam int unsigned QTR    = 2 ** A_W;
  localparam int unsigned LSB_W  = PHASE_W - LUT_BITS;

  localparam logic signed [SUM_W-1:0] RND  = SUM_W'(2 ** (COEF_W - 2));
  localparam logic signed [SUM_W-1:0] MAXV = SUM_W'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [SUM_W-1:0] MINV = -MAXV - SUM_W'(1);

  // Elaboration-time sine: round(32767*sin(2*pi*idx/2^LUT_BITS)) via Taylor series.
  function automatic logic signed [COEF_W-1:0] quarter_sine(input int unsigned idx);
    real x;
    real term;
    real acc;
    x    = 6.283185307179586 * real'(idx) / real'(2 ** LUT_BITS);
    term = x;
    acc  = x;
    for (int n = 1; n < 12; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      acc  = acc + term;
    end
    return COEF_W'($rtoi(32767.0 * acc + 0.5));
  endfunction

  // Add half an LSB, drop the Q1.15 fraction, clamp to the sample range.
  function automatic logic signed [DATA_W-1:0] rnd_sat(input logic signed [SUM_W-1:0] s);
    logic signed [SUM_W-1:0] sh;
    sh = (s + RND) >>> (COEF_W - 1);
    if (sh > MAXV)      return DATA_W'(MAXV);
    else if (sh < MINV) return DATA_W'(MINV);
    else                return DATA_W'(sh);
  endfunction

  logic signed [COEF_W-1:0] w_rom [QTR+1];

  for (genvar g = 0; g <= int'(QTR); g++) begin : g_rom
    localparam logic signed [COEF_W-1:0] T_VAL = quarter_sine(g);
    assign w_rom[g] = T_VAL;
  end

  for (genvar k = 0; k < int'(LANES); k++) begin : g_lane
    logic        [LUT_BITS-1:0] r_phase;
    logic signed [DATA_W-1:0]   r_i1, r_q1, r_i2, r_q2;
    logic signed [COEF_W-1:0]   r_sin, r_cos;
    logic signed [PROD_W-1:0]   r_p_ic, r_p_qs, r_p_is, r_p_qc;
    logic signed [DATA_W-1:0]   r_i_out, r_q_out;

    logic        [1:0]          w_quad;
    logic        [A_W-1:0]      w_addr;
    logic        [A_W:0]        w_addr_m;
    logic signed [COEF_W-1:0]   w_t_a, w_t_m, w_sin, w_cos;
    logic signed [SUM_W-1:0]    w_sum_i, w_sum_q;
    logic                       w_unused_lsbs;

    // Phase bits below the table resolution are truncated.
    assign w_unused_lsbs = ^phase_vals[k*PHASE_W +: LSB_W];

    assign w_quad   = r_phase[LUT_BITS-1 -: 2];
    assign w_addr   = r_phase[A_W-1:0];
    assign w_addr_m = (A_W+1)'(QTR) - {1'b0, w_addr};
    assign w_t_a    = w_rom[{1'b0, w_addr}];
    assign w_t_m    = w_rom[w_addr_m];

    always_comb begin
      w_sin = w_t_a;
      w_cos = w_t_m;
      case (w_quad)
        2'd0: begin w_sin =  w_t_a; w_cos =  w_t_m; end
        2'd1: begin w_sin =  w_t_m; w_cos = -w_t_a; end
        2'd2: begin w_sin = -w_t_a; w_cos = -w_t_m; end
        default: begin w_sin = -w_t_m; w_cos = w_t_a; end
      endcase
    end

    always_comb begin
`ifdef MULT_CONJ_EN
      w_sum_i = SUM_W'(r_p_ic) + SUM_W'(r_p_qs);
      w_sum_q = SUM_W'(r_p_qc) - SUM_W'(r_p_is);
`else
      w_sum_i = SUM_W'(r_p_ic) - SUM_W'(r_p_qs);
      w_sum_q = SUM_W'(r_p_is) + SUM_W'(r_p_qc);
`endif
    end

    // S1 capture, S2 coefficients, S3 products, S4 round/saturate.
    always_ff @(posedge clk100) begin
      if (reset) begin
        r_phase <= '0;
        r_i1    <= '0;
        r_q1    <= '0;
        r_i2    <= '0;
        r_q2    <= '0;
        r_sin   <= '0;
        r_cos   <= '0;
        r_p_ic  <= '0;
        r_p_qs  <= '0;
        r_p_is  <= '0;
        r_p_qc  <= '0;
        r_i_out <= '0;
        r_q_out <= '0;
      end else begin
        r_phase <= phase_vals[k*PHASE_W + LSB_W +: LUT_BITS];
        r_i1    <= data_i_in[k*DATA_W +: DATA_W];
        r_q1    <= data_q_in[k*DATA_W +: DATA_W];
        r_i2    <= r_i1;
        r_q2    <= r_q1;
        r_sin   <= w_sin;
        r_cos   <= w_cos;
        r_p_ic  <= PROD_W'(r_i2) * PROD_W'(r_cos);
        r_p_qs  <= PROD_W'(r_q2) * PROD_W'(r_sin);
        r_p_is  <= PROD_W'(r_i2) * PROD_W'(r_sin);
        r_p_qc  <= PROD_W'(r_q2) * PROD_W'(r_cos);
        r_i_out <= rnd_sat(w_sum_i);
        r_q_out <= rnd_sat(w_sum_q);
      end
    end

    assign data_i_rot[k*DATA_W +: DATA_W] = r_i_out;
    assign data_q_rot[k*DATA_W +: DATA_W] = r_q_out;
  end

endmodule

// File: tb/tb_iq_rotator.sv
// Directed self-checking bench for iq_rotator (both default and MULT_CONJ_EN builds).
module tb_iq_rotator;

  localparam int LANES = 5;
  localparam int DW    = 16;
  localparam int PW    = 14;
`ifdef MULT_CONJ_EN
  localparam bit CONJ = 1'b1;
`else
  localparam bit CONJ = 1'b0;
`endif

  logic                  clk100;
  logic                  reset;
  logic [LANES*PW-1:0]   phase_vals;
  logic [LANES*DW-1:0]   data_i_in;
  logic [LANES*DW-1:0]   data_q_in;
  logic [LANES*DW-1:0]   data_i_rot;
  logic [LANES*DW-1:0]   data_q_rot;

  int n_checks;
  int n_errors;

  iq_rotator dut (
    .clk100     (clk100),
    .reset      (reset),
    .phase_vals (phase_vals),
    .data_i_in  (data_i_in),
    .data_q_in  (data_q_in),
    .data_i_rot (data_i_rot),
    .data_q_rot (data_q_rot)
  );

  initial clk100 = 1'b0;
  always #5 clk100 = ~clk100;

  task automatic step();
    @(posedge clk100);
    #1;
  endtask

  task automatic set_lane(input int k, input int ph, input int i, input int q);
    phase_vals[k*PW +: PW] = PW'(ph);
    data_i_in[k*DW +: DW]  = DW'(i);
    data_q_in[k*DW +: DW]  = DW'(q);
  endtask

  task automatic set_all(input int ph, input int i, input int q);
    for (int k = 0; k < LANES; k++) set_lane(k, ph, i, q);
  endtask

  task automatic check_lane(input string tag, input int k, input int exp_i, input int exp_q);
    logic signed [DW-1:0] oi;
    logic signed [DW-1:0] oq;
    logic signed [DW-1:0] ei;
    logic signed [DW-1:0] eq;
    oi = data_i_rot[k*DW +: DW];
    oq = data_q_rot[k*DW +: DW];
    ei = DW'(exp_i);
    eq = DW'(exp_q);
    n_checks++;
    assert (oi === ei && oq === eq) else begin
      n_errors++;
      $error("FAIL %s lane%0d: observed I=%0d Q=%0d expected I=%0d Q=%0d", tag, k, oi, oq, ei, eq);
    end
  endtask

  task automatic check_all(input string tag, input int exp_i, input int exp_q);
    for (int k = 0; k < LANES; k++) check_lane(tag, k, exp_i, exp_q);
  endtask

  // Apply one vector to every lane and let it travel the full pipeline.
  task automatic run_all(input int ph, input int i, input int q);
    set_all(ph, i, q);
    repeat (4) step();
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    reset      = 1'b1;
    phase_vals = '0;
    data_i_in  = '0;
    data_q_in  = '0;
    set_all(14'h1234, 555, -777);
    step();
    step();
    check_all("reset_hold", 0, 0);

    set_all(0, 1000, 0);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check_all("post_release_zero", 0, 0);
    end
    step();
    check_all("post_release_first", 1000, 0);

    run_all(14'h1000, 1000, 0);
    check_all("quad1", 0, CONJ ? -1000 : 1000);
    run_all(14'h2000, 1000, 0);
    check_all("quad2", -1000, 0);
    run_all(14'h3000, 1000, 0);
    check_all("quad3", 0, CONJ ? 1000 : -1000);

    run_all(14'h0800, -32768, -32768);
    check_all("deg45_neg_sat", CONJ ? -32768 : 0, CONJ ? 0 : -32768);
    run_all(14'h0800, 1000, 1000);
    check_all("deg45_1000", CONJ ? 1414 : 0, CONJ ? 0 : 1414);
    run_all(14'h0800, 32767, 32767);
    check_all("deg45_pos_sat", CONJ ? 32767 : 0, CONJ ? 0 : 32767);
    run_all(14'h3FFF, 1000, 0);
    check_all("phase_3fff", 1000, CONJ ? 6 : -6);
    run_all(14'h0000, 1000, 0);
    check_all("phase_wrap0", 1000, 0);
    run_all(14'h2000, -32768, 0);
    check_all("min_in_180", 32767, 0);
    run_all(14'h000F, 1000, 0);
    check_all("lsb_truncate", 1000, 0);

    set_lane(0, 14'h0000, 1000, 0);
    set_lane(1, 14'h1000, 1000, 0);
    set_lane(2, 14'h2000, 1000, 0);
    set_lane(3, 14'h3000, 1000, 0);
    set_lane(4, 14'h0800, 1000, 0);
    repeat (4) step();
    check_lane("lanes", 0, 1000, 0);
    check_lane("lanes", 1, 0, CONJ ? -1000 : 1000);
    check_lane("lanes", 2, -1000, 0);
    check_lane("lanes", 3, 0, CONJ ? 1000 : -1000);
    check_lane("lanes", 4, 707, CONJ ? -707 : 707);

    // Ramp: value captured at edge t shows up after edge t+3 (four register stages).
    for (int t = 0; t < 20; t++) begin
      for (int k = 0; k < LANES; k++) set_lane(k, 0, 100 * k + k * t, -7 - k * t);
      step();
      if (t >= 3) begin
        for (int k = 0; k < LANES; k++)
          check_lane("stream", k, 100 * k + k * (t - 3), -7 - k * (t - 3));
      end
    end

    reset = 1'b1;
    step();
    check_all("midstream_reset", 0, 0);
    set_all(0, 1000, 0);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check_all("flush_zero", 0, 0);
    end
    step();
    check_all("flush_first", 1000, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
